// File: rtl/rd_fram_pkg.sv
// Shared types and constants for the read-side frame buffer controller.
package rd_fram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        REQ   = 2'd2,
        DRAIN = 2'd3
    } rd_fram_state_e;

    localparam int DDR_DW_DEF = 256;
    localparam int PIX_DW_DEF = 32;
    localparam int RATIO      = DDR_DW_DEF / PIX_DW_DEF;

    // Bit positions inside the sticky err vector.
    localparam int ERR_BUSY_START = 0;
    localparam int ERR_UNSOL      = 1;

endpackage

// File: rtl/rd_fram_buf_ctrl_if.sv
// Frame control, DDR read request/return and pixel stream of the frame buffer reader.
interface rd_fram_buf_ctrl_if #(
    parameter int DDR_DW = 256,
    parameter int PIX_DW = 32,
    parameter int ADDR_W = 28
);
    logic              frame_start;
    logic              ddr_req;
    logic [ADDR_W-1:0] ddr_req_addr;
    logic [7:0]        ddr_req_len;
    logic              ddr_req_ack;
    logic [DDR_DW-1:0] ddr_rdata;
    logic              ddr_rvalid;
    logic [PIX_DW-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              frame_busy;
    logic              frame_done;
    logic [1:0]        err;

    // Handshakes: a request transfers in a cycle with ddr_req&ddr_req_ack, and addr/len stay
    // stable while ddr_req waits; ddr_rvalid has no ready and is taken every cycle it is high;
    // a pixel transfers in a cycle with pix_valid&pix_ready, and pix_data holds while it waits.
    modport master (
        input  frame_start, ddr_req_ack, ddr_rdata, ddr_rvalid, pix_ready,
        output ddr_req, ddr_req_addr, ddr_req_len, pix_data, pix_valid,
               frame_busy, frame_done, err
    );

    modport slave (
        output frame_start, ddr_req_ack, ddr_rdata, ddr_rvalid, pix_ready,
        input  ddr_req, ddr_req_addr, ddr_req_len, pix_data, pix_valid,
               frame_busy, frame_done, err
    );

endinterface

// File: rtl/rd_fram_ram.sv
// Single-clock simple dual-port beat buffer with a registered read port.
module rd_fram_ram #(
    parameter int AW = 4,
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rd_fram_buf_ctrl.sv
// Reads one frame from DDR in credit-limited bursts, buffers the beats and
// streams them out as 32-bit pixels, LSB pixel of each beat first.
module rd_fram_buf_ctrl
    import rd_fram_pkg::*;
#(
    parameter int DDR_DW      = 256,
    parameter int PIX_DW      = 32,
    parameter int BUF_AW      = 4,
    parameter int BURST_LEN   = 8,
    parameter int ADDR_W      = 28,
    parameter int FRAME_BASE  = 0,
    parameter int FRAME_WORDS = 115200
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst_n,
    rd_fram_buf_ctrl_if.master       bus,
    output rd_fram_state_e           state_dbg
);

    localparam int DEPTH = 1 << BUF_AW;
    localparam int CW    = BUF_AW + 1;
    localparam int IW    = $clog2(RATIO);

    rd_fram_state_e    state, state_n;
    logic [CW-1:0]     stored, outstanding;
    logic [31:0]       words_left, free, need;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [BUF_AW-1:0] wr_ptr, rd_ptr;
    logic [IW-1:0]     idx;
    logic              pix_valid_q, frame_done_q;
    logic [1:0]        err_q, err_set;
    logic [DDR_DW-1:0] beat;

    logic wr_beat, unsol, pix_hs, last_sub, ld, ack_fire;
    logic start_ok, launch, done_now, busy_start;

    assign wr_beat  = bus.ddr_rvalid && (outstanding != '0);
    assign unsol    = bus.ddr_rvalid && (outstanding == '0);
    assign pix_hs   = pix_valid_q && bus.pix_ready;
    assign last_sub = pix_hs && (idx == IW'(RATIO - 1));
    // Refill the output stage when it is empty or its last pixel leaves this cycle.
    assign ld       = (stored != '0) && (!pix_valid_q || last_sub);
    assign ack_fire = (state == REQ) && bus.ddr_req_ack;
    assign free     = 32'(DEPTH) - 32'(stored) - 32'(outstanding);
    assign need     = (words_left < 32'(BURST_LEN)) ? words_left : 32'(BURST_LEN);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        start_ok   = 1'b0;
        launch     = 1'b0;
        done_now   = 1'b0;
        busy_start = bus.frame_start && (state != IDLE);
        case (state)
            IDLE: begin
                if (bus.frame_start) begin
                    start_ok = 1'b1;
                    state_n  = FILL;
                end
            end
            FILL: begin
                if (words_left == '0) begin
                    state_n = DRAIN;
                end else if (free >= need) begin
                    launch  = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (bus.ddr_req_ack) begin
                    state_n = FILL;
                end
            end
            DRAIN: begin
                if (stored == '0 && outstanding == '0 && (!pix_valid_q || last_sub)) begin
                    done_now = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        err_set                 = '0;
        err_set[ERR_BUSY_START] = busy_start;
        err_set[ERR_UNSOL]      = unsol;
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            stored       <= '0;
            outstanding  <= '0;
            words_left   <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            idx          <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= '0;
        end else begin
            stored       <= stored + CW'(wr_beat) - CW'(ld);
            outstanding  <= outstanding + (ack_fire ? CW'(len_q) : CW'(0)) - CW'(wr_beat);
            frame_done_q <= done_now;
            err_q        <= (start_ok ? 2'b00 : err_q) | err_set;
            if (start_ok) begin
                addr_q     <= ADDR_W'(FRAME_BASE);
                words_left <= 32'(FRAME_WORDS);
            end else if (ack_fire) begin
                addr_q     <= addr_q + ADDR_W'(len_q);
                words_left <= words_left - 32'(len_q);
            end
            if (launch) begin
                len_q <= 8'(need);
            end
            if (wr_beat) begin
                wr_ptr <= wr_ptr + BUF_AW'(1);
            end
            if (ld) begin
                rd_ptr      <= rd_ptr + BUF_AW'(1);
                idx         <= '0;
                pix_valid_q <= 1'b1;
            end else if (pix_hs) begin
                idx <= idx + IW'(1);
                if (last_sub) begin
                    pix_valid_q <= 1'b0;
                end
            end
        end
    end

    // The RAM's read register doubles as the output stage's beat holder.
    rd_fram_ram #(
        .AW (BUF_AW),
        .DW (DDR_DW)
    ) u_ram (
        .clk   (rd_clk),
        .we    (wr_beat),
        .waddr (wr_ptr),
        .wdata (bus.ddr_rdata),
        .re    (ld),
        .raddr (rd_ptr),
        .rdata (beat)
    );

    assign bus.ddr_req      = (state == REQ);
    assign bus.ddr_req_addr = addr_q;
    assign bus.ddr_req_len  = len_q;
    assign bus.pix_valid    = pix_valid_q;
    assign bus.pix_data     = pix_valid_q ? beat[32'(idx) * PIX_DW +: PIX_DW] : '0;
    assign bus.frame_busy   = (state != IDLE);
    assign bus.frame_done   = frame_done_q;
    assign bus.err          = err_q;
    assign state_dbg        = state;

endmodule

// File: tb/tb_rd_fram_buf_ctrl.sv
// Bench for rd_fram_buf_ctrl: DDR responder, pixel scoreboard and directed/random frames.
module tb_rd_fram_buf_ctrl;
    import rd_fram_pkg::*;

    localparam int DDR_DW      = 256;
    localparam int PIX_DW      = 32;
    localparam int BUF_AW      = 4;
    localparam int BURST_LEN   = 8;
    localparam int ADDR_W      = 28;
    localparam int FRAME_WORDS = 20;

    logic           rd_clk = 1'b0;
    logic           rd_rst_n = 1'b0;
    rd_fram_state_e state_dbg;

    rd_fram_buf_ctrl_if #(.DDR_DW(DDR_DW), .PIX_DW(PIX_DW), .ADDR_W(ADDR_W)) bus ();

    rd_fram_buf_ctrl #(
        .DDR_DW      (DDR_DW),
        .PIX_DW      (PIX_DW),
        .BUF_AW      (BUF_AW),
        .BURST_LEN   (BURST_LEN),
        .ADDR_W      (ADDR_W),
        .FRAME_BASE  (0),
        .FRAME_WORDS (FRAME_WORDS)
    ) dut (
        .rd_clk    (rd_clk),
        .rd_rst_n  (rd_rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 rd_clk = ~rd_clk;

    int checks = 0;
    int errors = 0;
    logic [PIX_DW-1:0]   exp_q[$];
    logic [ADDR_W+7:0]   exp_req_q[$];
    int pix_cnt = 0, done_cnt = 0, req_cnt = 0, req_high_cnt = 0, last_req_pix = 0;
    int ready_mode = 1, ack_min = 0, ack_max = 0, lat_min = 3, lat_max = 3;
    int cyc = 0, frame_d0 = 0, frame_p0 = 0;
    bit hold_ack = 0, inject_unsol = 0, flush_resp = 0;
    logic [31:0] salt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Beat at address a holds pixels s+8a .. s+8a+7, LSB pixel first.
    function automatic logic [DDR_DW-1:0] mk_beat(input logic [31:0] s, input int a);
        logic [DDR_DW-1:0] b;
        for (int j = 0; j < 8; j++) b[j*32 +: 32] = s + 32'(8 * a + j);
        return b;
    endfunction

    // DDR responder: acks after a random wait, returns beats a random latency after the ack.
    initial begin : responder
        int a_q[$];
        int due_q[$];
        int wait_left, lat, due, last_due;
        bit in_req;
        bus.ddr_req_ack = 1'b0;
        bus.ddr_rvalid  = 1'b0;
        bus.ddr_rdata   = '0;
        wait_left = 0; last_due = 0; in_req = 0;
        forever begin
            @(negedge rd_clk);
            cyc++;
            if (flush_resp) begin
                a_q.delete(); due_q.delete(); in_req = 0; flush_resp = 0;
            end
            bus.ddr_rvalid = 1'b0;
            bus.ddr_rdata  = '0;
            if (inject_unsol) begin
                bus.ddr_rvalid = 1'b1;
                bus.ddr_rdata  = mk_beat(32'hdead_0000, 0);
                inject_unsol   = 0;
            end else if (a_q.size() > 0 && due_q[0] <= cyc) begin
                bus.ddr_rvalid = 1'b1;
                bus.ddr_rdata  = mk_beat(salt, a_q.pop_front());
                void'(due_q.pop_front());
            end
            bus.ddr_req_ack = 1'b0;
            if (bus.ddr_req === 1'b1) begin
                req_high_cnt++;
                if (!in_req) begin
                    in_req = 1;
                    wait_left = $urandom_range(ack_max, ack_min);
                end
                if (!hold_ack) begin
                    if (wait_left == 0) begin
                        bus.ddr_req_ack = 1'b1;
                        in_req = 0;
                        req_cnt++;
                        last_req_pix = pix_cnt;
                        check("req_expected", 64'(exp_req_q.size() > 0), 64'(1));
                        if (exp_req_q.size() > 0)
                            check("req_addr_len", 64'({bus.ddr_req_addr, bus.ddr_req_len}),
                                  64'(exp_req_q.pop_front()));
                        lat = $urandom_range(lat_max, lat_min);
                        for (int i = 0; i < int'(bus.ddr_req_len); i++) begin
                            due = cyc + lat + i;
                            if (due <= last_due) due = last_due + 1;
                            last_due = due;
                            a_q.push_back(int'(bus.ddr_req_addr) + i);
                            due_q.push_back(due);
                        end
                    end else begin
                        wait_left--;
                    end
                end
            end else begin
                in_req = 0;
            end
        end
    end

    // Consumer ready: 0 = stalled, 1 = always ready, 2 = random.
    initial begin : ready_drv
        bus.pix_ready = 1'b0;
        forever begin
            @(posedge rd_clk);
            #1;
            case (ready_mode)
                0:       bus.pix_ready = 1'b0;
                1:       bus.pix_ready = 1'b1;
                default: bus.pix_ready = ($urandom_range(3, 0) != 0);
            endcase
        end
    end

    // Scoreboard monitor: pops one expected pixel per handshake, audits frame_done.
    initial begin : pix_mon
        forever begin
            @(negedge rd_clk);
            if (rd_rst_n && bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
                pix_cnt++;
                check("pix_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) check("pixel", 64'(bus.pix_data), 64'(exp_q.pop_front()));
            end
            if (rd_rst_n && bus.frame_done === 1'b1) begin
                done_cnt++;
                check("busy_at_done", 64'(bus.frame_busy), 64'(0));
                check("pix_left_at_done", 64'(exp_q.size()), 64'(0));
            end
        end
    end

    task automatic pulse_start();
        @(posedge rd_clk);
        #1;
        bus.frame_start = 1'b1;
        @(posedge rd_clk);
        #1;
        bus.frame_start = 1'b0;
    endtask

    // Pushes the frame's expected requests and pixels, starts it and checks the first request.
    task automatic begin_frame(input logic [31:0] s);
        int len;
        salt = s;
        for (int a = 0; a < FRAME_WORDS; a += len) begin
            len = (FRAME_WORDS - a < BURST_LEN) ? FRAME_WORDS - a : BURST_LEN;
            exp_req_q.push_back({ADDR_W'(a), 8'(len)});
        end
        for (int n = 0; n < FRAME_WORDS * 8; n++) exp_q.push_back(s + 32'(n));
        frame_d0 = done_cnt;
        frame_p0 = pix_cnt;
        pulse_start();
        check("busy_after_start", 64'(bus.frame_busy), 64'(1));
        check("err_clear_on_start", 64'(bus.err), 64'(0));
        check("req_not_at_n1", 64'(bus.ddr_req), 64'(0));
        @(posedge rd_clk);
        #1;
        check("req_at_n2", 64'(bus.ddr_req), 64'(1));
        check("first_req_addr", 64'(bus.ddr_req_addr), 64'(0));
        check("first_req_len", 64'(bus.ddr_req_len), 64'(BURST_LEN));
    endtask

    task automatic wait_frame(input logic [1:0] exp_err);
        int bud;
        bud = 0;
        while (done_cnt == frame_d0 && bud < 4000) begin
            @(posedge rd_clk);
            #1;
            bud++;
        end
        check("frame_done_seen", 64'(done_cnt != frame_d0), 64'(1));
        repeat (4) @(posedge rd_clk);
        #1;
        check("frame_done_once", 64'(done_cnt - frame_d0), 64'(1));
        check("frame_pixels", 64'(pix_cnt - frame_p0), 64'(FRAME_WORDS * 8));
        check("req_left", 64'(exp_req_q.size()), 64'(0));
        check("busy_after_done", 64'(bus.frame_busy), 64'(0));
        check("err_after_frame", 64'(bus.err), 64'(exp_err));
    endtask

    initial begin : main
        int h0, r0;
        bus.frame_start = 1'b0;
        rd_rst_n = 1'b0;
        repeat (3) @(posedge rd_clk);
        #1;
        check("rst_ddr_req", 64'(bus.ddr_req), 64'(0));
        check("rst_req_addr", 64'(bus.ddr_req_addr), 64'(0));
        check("rst_req_len", 64'(bus.ddr_req_len), 64'(0));
        check("rst_pix_valid", 64'(bus.pix_valid), 64'(0));
        check("rst_pix_data", 64'(bus.pix_data), 64'(0));
        check("rst_busy", 64'(bus.frame_busy), 64'(0));
        check("rst_done", 64'(bus.frame_done), 64'(0));
        check("rst_err", 64'(bus.err), 64'(0));
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        rd_rst_n = 1'b1;
        h0 = req_high_cnt;
        repeat (20) @(posedge rd_clk);
        #1;
        check("no_req_without_start", 64'(req_high_cnt - h0), 64'(0));

        // Nominal frame: immediate ack, beats 3 cycles after the ack, consumer always ready.
        begin_frame(32'd0);
        wait_frame(2'b00);

        // Backpressure: 16 credits cover only two bursts while nothing drains.
        ready_mode = 0;
        r0 = req_cnt;
        begin_frame(32'h0001_0000);
        repeat (80) @(posedge rd_clk);
        #1;
        check("bp_two_requests", 64'(req_cnt - r0), 64'(2));
        check("bp_no_req", 64'(bus.ddr_req), 64'(0));
        check("bp_valid_held", 64'(bus.pix_valid), 64'(1));
        ready_mode = 1;
        wait_frame(2'b00);
        // One beat sits in the output stage, so free reaches 4 only after three more leave the buffer.
        check("bp_third_req_late", 64'(last_req_pix - frame_p0 >= 24), 64'(1));

        // frame_start while waiting for an ack.
        ack_min = 4;
        ack_max = 4;
        begin_frame(32'h0002_0000);
        pulse_start();
        check("busy_start_err", 64'(bus.err), 64'(2'b01));
        check("busy_start_busy", 64'(bus.frame_busy), 64'(1));
        wait_frame(2'b01);

        // Random frames: random ack wait, beat latency and consumer stalls.
        ready_mode = 2;
        ack_min = 0;
        ack_max = 3;
        lat_min = 1;
        lat_max = 6;
        for (int f = 0; f < 3; f++) begin
            begin_frame($urandom);
            wait_frame(2'b00);
        end
        ready_mode = 1;

        // Reset while a request is pending.
        hold_ack = 1;
        begin_frame(32'h0003_0000);
        rd_rst_n = 1'b0;
        #1;
        check("midrst_req_drop", 64'(bus.ddr_req), 64'(0));
        check("midrst_busy", 64'(bus.frame_busy), 64'(0));
        check("midrst_state", 64'(state_dbg), 64'(IDLE));
        exp_q.delete();
        exp_req_q.delete();
        flush_resp = 1;
        hold_ack = 0;
        repeat (2) @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;

        // Unsolicited beat in IDLE.
        @(posedge rd_clk);
        #1;
        inject_unsol = 1;
        repeat (6) @(posedge rd_clk);
        #1;
        check("unsol_err", 64'(bus.err), 64'(2'b10));
        check("unsol_no_pixel", 64'(bus.pix_valid), 64'(0));

        // Post-reset frame restarts from address 0 and clears err.
        begin_frame(32'h0004_0000);
        wait_frame(2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
